// File: rtl/filter_mode_ctrl.sv
// filter_mode_ctrl: frame-synchronous mode controller for the green-screen
// keyer. A debounced push-button and an optional demo cycle both step a
// requested mode. The requested mode is only committed to the keyer settings
// on a vsync falling edge, so a frame is never keyed with mixed settings.
module filter_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DEMO_FRAMES     = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic       vs,
  input  logic       demo_en,
  output logic       gsc_en,
  output logic [8:0] thr_lo,
  output logic [8:0] thr_hi,
  output logic [1:0] mode,
  output logic       pending,
  output logic       mode_changed
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_t;

  // One row of the keying-mode table.
  typedef struct packed {
    logic       en;
    logic [8:0] lo;
    logic [8:0] hi;
  } mode_cfg_t;

  // The debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     DEMO_LAST = 16'(DEMO_FRAMES - 1);

  // Keying table; every row keeps lo <= hi.
  function automatic mode_cfg_t mode_cfg(input logic [1:0] m);
    mode_cfg_t cfg;
    // NOTE: the default arm (and the explicit start value) keep this decode
    // fully specified on every path, so nothing here can infer a latch.
    cfg = '{en: 1'b0, lo: 9'd90, hi: 9'd150};
    case (m)
      2'd0:    cfg = '{en: 1'b0, lo: 9'd90,  hi: 9'd150};
      2'd1:    cfg = '{en: 1'b1, lo: 9'd90,  hi: 9'd150};
      2'd2:    cfg = '{en: 1'b1, lo: 9'd60,  hi: 9'd180};
      2'd3:    cfg = '{en: 1'b1, lo: 9'd100, hi: 9'd130};
      default: cfg = '{en: 1'b0, lo: 9'd90,  hi: 9'd150};
    endcase
    return cfg;
  endfunction

  logic            key_meta;
  logic            key_sync;
  logic            key_s;
  db_state_t       db_state;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  logic            vs_q;
  logic            frame_tick;
  logic [15:0]     demo_cnt;
  logic            demo_adv;
  logic [1:0]      req_mode;
  logic [1:0]      req_next;
  logic [1:0]      mode_next;
  logic            commit;
  mode_cfg_t       commit_cfg;

  // Two-flop synchronizer for the asynchronous button; idles released (1).
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments make both flops sample pre-edge values,
    // which is what turns these two statements into a real two-stage chain.
    if (rst) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  assign key_s = ~key_sync;

  // Debounce FSM: one shared counter, cleared whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_state <= IDLE;
      db_cnt   <= '0;
    end else begin
      case (db_state)
        IDLE: begin
          if (key_s) begin
            db_state <= PRESS_WAIT;
            db_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_s) begin
            db_state <= IDLE;
            db_cnt   <= '0;
          end else if (db_cnt == DB_LAST) begin
            db_state <= HELD;
            db_cnt   <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!key_s) begin
            db_state <= RELEASE_WAIT;
            db_cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (key_s) begin
            db_state <= HELD;
            db_cnt   <= '0;
          end else if (db_cnt == DB_LAST) begin
            db_state <= IDLE;
            db_cnt   <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          db_state <= IDLE;
          db_cnt   <= '0;
        end
      endcase
    end
  end

  // The press strobe marks the PRESS_WAIT -> HELD edge, so a held key
  // yields exactly one press.
  assign press = (db_state == PRESS_WAIT) && key_s && (db_cnt == DB_LAST);

  // Register vsync to find its falling edge; idles inactive-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vs_q <= 1'b1;
    else     vs_q <= vs;
  end

  assign frame_tick = vs_q & ~vs;

  // Demo frame counter: runs on frame ticks only while demo is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      demo_cnt <= '0;
    end else if (!demo_en) begin
      demo_cnt <= '0;
    end else if (frame_tick) begin
      if (demo_cnt == DEMO_LAST) demo_cnt <= '0;
      else                       demo_cnt <= demo_cnt + 16'd1;
    end
  end

  assign demo_adv = demo_en && frame_tick && (demo_cnt == DEMO_LAST);

  // A coincident press and demo step still advance the request by one.
  assign req_next = (press || demo_adv) ? 2'(req_mode + 2'd1) : req_mode;

  // The commit takes the request as it stood before this cycle's advance;
  // a same-cycle advance waits for the next frame.
  assign commit     = frame_tick && (req_mode != mode);
  assign mode_next  = commit ? req_mode : mode;
  assign commit_cfg = mode_cfg(req_mode);

  // Request, committed mode and keyer settings; all change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_mode     <= 2'd0;
      mode         <= 2'd0;
      pending      <= 1'b0;
      mode_changed <= 1'b0;
      gsc_en       <= 1'b0;
      thr_lo       <= 9'd90;
      thr_hi       <= 9'd150;
    end else begin
      req_mode     <= req_next;
      mode         <= mode_next;
      pending      <= (req_next != mode_next);
      mode_changed <= commit;
      if (commit) begin
        gsc_en <= commit_cfg.en;
        thr_lo <= commit_cfg.lo;
        thr_hi <= commit_cfg.hi;
      end
    end
  end

endmodule
